// File: rtl/nor_idle_pkg.sv
// Shared defaults and helpers for the registered NOR idle detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nor_idle_pkg;

   localparam int DEF_CHANNELS = 4;
   localparam int DEF_WIDTH    = 4;
   localparam int DEF_THRESH   = 8;

   // Run-length counters restart from this value after reset, a non-zero sample or EN low.
   localparam int CNT_RST_VAL  = 0;

   // Counter width that can hold every value 0..thresh inclusive.
   function automatic int calc_cw(input int thresh);
      return $clog2(thresh + 1);
   endfunction

endpackage

// File: rtl/nor_idle_chan.sv
// One channel: registered NOR of a slice plus a saturating all-zero run counter driving IDLE.
// Latency: ZN 1 cycle; IDLE rises on the THRESH-th consecutive qualified all-zero sample, falls on the first miss.
// Backpressure: none, a new sample is taken every cycle. NOR_IDLE_STICKY_EN adds clr/sticky.
module nor_idle_chan
   import nor_idle_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int THRESH = DEF_THRESH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic             en,
`ifdef NOR_IDLE_STICKY_EN
   input  logic             clr,
   output logic             sticky,
`endif
   output logic             zn,
   output logic             idle
);

   localparam int              CW       = calc_cw(THRESH);
   localparam logic [CW-1:0]   THRESH_V = CW'(THRESH);
   localparam logic [CW-1:0]   CNT_RST  = CW'(CNT_RST_VAL);

   logic          z;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          idle_next;

   // NOR of the slice and the saturating run-length update; IDLE is decoded from the next count.
   always_comb begin
      z         = ~|a;
      cnt_next  = CNT_RST;
      if (en && z) begin
         cnt_next = (cnt == THRESH_V) ? THRESH_V : cnt + CW'(1);
      end
      idle_next = (cnt_next == THRESH_V);
   end

   // ZN, counter and IDLE registers; ZN follows the slice regardless of EN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zn   <= 1'b0;
         cnt  <= CNT_RST;
         idle <= 1'b0;
      end else begin
         zn   <= z;
         cnt  <= cnt_next;
         idle <= idle_next;
      end
   end

`ifdef NOR_IDLE_STICKY_EN
   // Sticky idle-seen flag: sets on an IDLE rising edge, which beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky <= 1'b0;
      end else if (idle_next && !idle) begin
         sticky <= 1'b1;
      end else if (clr) begin
         sticky <= 1'b0;
      end
   end
`endif

endmodule

// File: rtl/nor_idle_detect.sv
// Multi-channel registered NOR / bus-quiet detector with per-channel idle qualification (option: NOR_IDLE_STICKY_EN).
// Latency: ZN 1 cycle from A; IDLE after THRESH qualified zero samples; ALL_IDLE/ANY_IDLE add none.
// Backpressure: none, every channel samples its slice on every clock.
module nor_idle_detect
   import nor_idle_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int THRESH   = DEF_THRESH
) (
   input  logic                      CLK,
   input  logic                      RN,
   input  logic [CHANNELS*WIDTH-1:0] A,
   input  logic                      EN,
`ifdef NOR_IDLE_STICKY_EN
   input  logic                      CLR,
   output logic [CHANNELS-1:0]       STICKY,
`endif
   output logic [CHANNELS-1:0]       ZN,
   output logic [CHANNELS-1:0]       IDLE,
   output logic                      ALL_IDLE,
   output logic                      ANY_IDLE
);

   // Channels are fully independent; one instance per slice.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      nor_idle_chan #(
         .WIDTH  (WIDTH),
         .THRESH (THRESH)
      ) u_chan (
         .clk    (CLK),
         .rst_n  (RN),
         .a      (A[c*WIDTH +: WIDTH]),
         .en     (EN),
`ifdef NOR_IDLE_STICKY_EN
         .clr    (CLR),
         .sticky (STICKY[c]),
`endif
         .zn     (ZN[c]),
         .idle   (IDLE[c])
      );
   end

   // Cross-channel summaries straight off the IDLE registers.
   always_comb begin
      ALL_IDLE = &IDLE;
      ANY_IDLE = |IDLE;
   end

endmodule

// File: tb/tb_nor_idle_detect.sv
// Bench for nor_idle_detect: default configuration plus a THRESH=1, 2-channel, 3-bit instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_nor_idle_detect;

   localparam int T0 = 8;
   localparam int T1 = 1;

   logic        CLK = 1'b0;
   logic        RN;
   logic        EN;
   logic        CLR;
   logic [15:0] A0;
   logic [5:0]  A1;

   logic [3:0]  zn0, idle0;
   logic        all0, any0;
   logic [1:0]  zn1, idle1;
   logic        all1, any1;
`ifdef NOR_IDLE_STICKY_EN
   logic [3:0]  st0;
   logic [1:0]  st1;
`endif

   int total = 0;
   int bad   = 0;

   // reference model: unbounded run lengths, idle = run >= threshold
   int          run0[4];
   int          run1[2];
   logic [3:0]  zn_m0, idle_m0, st_m0;
   logic [1:0]  zn_m1, idle_m1, st_m1;

   always #5 CLK = ~CLK;

   nor_idle_detect #(.CHANNELS(4), .WIDTH(4), .THRESH(T0)) dut0 (
      .CLK      (CLK),
      .RN       (RN),
      .A        (A0),
      .EN       (EN),
`ifdef NOR_IDLE_STICKY_EN
      .CLR      (CLR),
      .STICKY   (st0),
`endif
      .ZN       (zn0),
      .IDLE     (idle0),
      .ALL_IDLE (all0),
      .ANY_IDLE (any0)
   );

   nor_idle_detect #(.CHANNELS(2), .WIDTH(3), .THRESH(T1)) dut1 (
      .CLK      (CLK),
      .RN       (RN),
      .A        (A1),
      .EN       (EN),
`ifdef NOR_IDLE_STICKY_EN
      .CLR      (CLR),
      .STICKY   (st1),
`endif
      .ZN       (zn1),
      .IDLE     (idle1),
      .ALL_IDLE (all1),
      .ANY_IDLE (any1)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) run0[c] = 0;
      for (int c = 0; c < 2; c++) run1[c] = 0;
      zn_m0 = '0; idle_m0 = '0; st_m0 = '0;
      zn_m1 = '0; idle_m1 = '0; st_m1 = '0;
   endtask

   task automatic check_model();
      check("zn0",   16'(zn0),   16'(zn_m0));
      check("idle0", 16'(idle0), 16'(idle_m0));
      check("all0",  16'(all0),  16'(&idle_m0));
      check("any0",  16'(any0),  16'(|idle_m0));
      check("zn1",   16'(zn1),   16'(zn_m1));
      check("idle1", 16'(idle1), 16'(idle_m1));
      check("all1",  16'(all1),  16'(&idle_m1));
      check("any1",  16'(any1),  16'(|idle_m1));
`ifdef NOR_IDLE_STICKY_EN
      check("st0",   16'(st0),   16'(st_m0));
      check("st1",   16'(st1),   16'(st_m1));
`endif
   endtask

   // one clock: advance the model with the inputs seen at the edge, then check on the falling edge
   task automatic edge_and_check();
      @(posedge CLK);
      for (int c = 0; c < 4; c++) begin
         logic z, was;
         z           = (A0[c*4 +: 4] == 4'd0);
         was         = idle_m0[c];
         run0[c]     = (EN && z) ? run0[c] + 1 : 0;
         idle_m0[c]  = (run0[c] >= T0);
         zn_m0[c]    = z;
         if (idle_m0[c] && !was) st_m0[c] = 1'b1;
         else if (CLR)           st_m0[c] = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
         logic z, was;
         z           = (A1[c*3 +: 3] == 3'd0);
         was         = idle_m1[c];
         run1[c]     = (EN && z) ? run1[c] + 1 : 0;
         idle_m1[c]  = (run1[c] >= T1);
         zn_m1[c]    = z;
         if (idle_m1[c] && !was) st_m1[c] = 1'b1;
         else if (CLR)           st_m1[c] = 1'b0;
      end
      @(negedge CLK);
      check_model();
   endtask

   // reset pulse strictly between edges; outputs must drop at once
   task automatic async_reset_pulse();
      #2 RN = 1'b0;
      #1;
      check("rst_zn0",   16'(zn0),   16'h0);
      check("rst_idle0", 16'(idle0), 16'h0);
      check("rst_idle1", 16'(idle1), 16'h0);
      check("rst_all0",  16'(all0),  16'h0);
`ifdef NOR_IDLE_STICKY_EN
      check("rst_st0",   16'(st0),   16'h0);
`endif
      model_reset();
      #1 RN = 1'b1;
   endtask

   initial begin
      RN = 1'b0; EN = 1'b0; CLR = 1'b0; A0 = '0; A1 = '0;
      model_reset();
      #12;
      check("reset_zn",   16'(zn0),   16'h0);
      check("reset_idle", 16'(idle0), 16'h0);
      check("reset_all",  16'(all0),  16'h0);
      check("reset_any",  16'(any0),  16'h0);

      // release with a quiet bus: ZN after one edge, IDLE after the 8th edge only
      @(negedge CLK);
      RN = 1'b1; EN = 1'b1;
      edge_and_check();
      check("zn_first_edge", 16'(zn0), 16'hF);
      repeat (6) edge_and_check();
      check("idle_edge7", 16'(idle0), 16'h0);
      edge_and_check();
      check("idle_edge8", 16'(idle0), 16'hF);
      check("all_edge8",  16'(all0),  16'h1);

      // one-cycle interrupt on ch0
      A0 = 16'h0001;
      edge_and_check();
      check("intr_idle", 16'(idle0), 16'hE);
      check("intr_zn",   16'(zn0),   16'hE);
      check("intr_any",  16'(any0),  16'h1);
      A0 = 16'h0000;
      repeat (7) edge_and_check();
      check("intr_idle_7", 16'(idle0), 16'hE);
      edge_and_check();
      check("intr_idle_8", 16'(idle0), 16'hF);

      // EN gating
      EN = 1'b0;
      repeat (20) edge_and_check();
      check("en_off_idle", 16'(idle0), 16'h0);
      check("en_off_zn",   16'(zn0),   16'hF);
      EN = 1'b1;
      repeat (7) edge_and_check();
      check("en_on_idle_7", 16'(idle0), 16'h0);
      edge_and_check();
      check("en_on_idle_8", 16'(idle0), 16'hF);
      EN = 1'b0;
      edge_and_check();
      check("en_drop_idle", 16'(idle0), 16'h0);

      // THRESH=1 instance: IDLE[1] tracks ZN[1] edge for edge
      EN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         A1 = (i % 2 == 1) ? 6'b100000 : 6'b000000;
         edge_and_check();
         check("t1_idle1", 16'(idle1[1]), (i % 2 == 1) ? 16'h0 : 16'h1);
         check("t1_zn1",   16'(zn1[1]),   (i % 2 == 1) ? 16'h0 : 16'h1);
      end
      A1 = '0;

      // async reset with the count part-way
      A0 = 16'hFFFF;
      edge_and_check();
      A0 = 16'h0000;
      repeat (5) edge_and_check();
      async_reset_pulse();
      repeat (7) edge_and_check();
      check("post_rst_idle_7", 16'(idle0), 16'h0);
      edge_and_check();
      check("post_rst_idle_8", 16'(idle0), 16'hF);

`ifdef NOR_IDLE_STICKY_EN
      A0 = 16'h0F00; CLR = 1'b1;
      edge_and_check();
      CLR = 1'b0;
      check("st2_cleared", 16'(st0[2]), 16'h0);
      A0 = 16'h0000;
      repeat (7) edge_and_check();
      check("st2_before", 16'(st0[2]), 16'h0);
      edge_and_check();
      check("st2_set", 16'(st0[2]), 16'h1);
      A0 = 16'h0100;
      edge_and_check();
      check("st2_hold",      16'(st0[2]),   16'h1);
      check("st2_idle_fell", 16'(idle0[2]), 16'h0);
      CLR = 1'b1;
      edge_and_check();
      CLR = 1'b0;
      check("st2_clr", 16'(st0[2]), 16'h0);
      A0 = 16'h0000;
      repeat (7) edge_and_check();
      CLR = 1'b1;
      edge_and_check();
      CLR = 1'b0;
      check("st2_set_wins", 16'(st0[2]),   16'h1);
      check("st2_idle_up",  16'(idle0[2]), 16'h1);
`endif

      // randomized traffic, mostly quiet slices
      for (int n = 0; n < 600; n++) begin
         for (int c = 0; c < 4; c++)
            A0[c*4 +: 4] = ($urandom_range(99) < 85) ? 4'h0 : 4'($urandom_range(15, 1));
         for (int c = 0; c < 2; c++)
            A1[c*3 +: 3] = ($urandom_range(99) < 70) ? 3'h0 : 3'($urandom_range(7, 1));
         EN  = ($urandom_range(15) != 0);
         CLR = ($urandom_range(7) == 0);
         edge_and_check();
         if ($urandom_range(63) == 0) async_reset_pulse();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
